// File: rtl/if_id_hazard_ctrl.sv
// Pipeline front-end hazard controller: load-use stall, taken-branch flush and memory-wait hold.
// Optional stall-cycle counter built only when IF_ID_STALL_COUNT_EN is defined.
module if_id_hazard_ctrl #(
  parameter int REG_W        = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             if_id_loadbar,
  output logic             pc_loadbar,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mem_timeout,
  output logic [15:0]      stall_count
);

  // state | meaning
  // RUN   | normal issue; evaluates mem_req > branch_taken > hazard
  // FLUSH | extra flush cycles after a taken branch (cnt counts down)
  // MWAIT | holding PC and IF/ID for a multi-cycle memory access (cnt = timeout budget)
  typedef enum logic [1:0] {RUN, FLUSH, MWAIT} state_t;

  localparam logic [7:0] TO_LOAD = 8'(MEM_TIMEOUT - 1);
  localparam logic [7:0] FL_LOAD = 8'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       hazard;
  logic       hold, flush, bubble, tout;

  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hold     = 1'b0;
    flush    = 1'b0;
    bubble   = 1'b0;
    tout     = 1'b0;
    case (state)
      RUN: begin
        // a zero-wait access (mem_req & mem_ready) does not stall, so branch/hazard still apply
        if (mem_req && !mem_ready) begin
          hold     = 1'b1;
          state_nx = MWAIT;
          cnt_nx   = TO_LOAD;
        end else if (branch_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nx = FLUSH;
            cnt_nx   = FL_LOAD;
          end
        end else if (hazard) begin
          hold   = 1'b1;
          bubble = 1'b1;
        end
      end
      FLUSH: begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (cnt == 8'd0) state_nx = RUN;
        else             cnt_nx   = cnt - 8'd1;
      end
      MWAIT: begin
        hold = 1'b1;
        if (mem_ready) begin
          state_nx = RUN;
        end else if (cnt == 8'd0) begin
          state_nx = RUN;
          tout     = 1'b1;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign if_id_loadbar = hold   & ~reset;
  assign pc_loadbar    = hold   & ~reset;
  assign if_id_flush   = flush  & ~reset;
  assign id_ex_bubble  = bubble & ~reset;
  assign mem_timeout   = tout   & ~reset;

`ifdef IF_ID_STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_q <= 16'h0000;
    else if ((hold || flush) && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'h0001;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule
